// File: rtl/ibex_rf_writeback.sv
// ibex_rf_writeback: arbitrates execute results and in-order load responses onto the register-file write port
// Ports: clk_i/rst_ni clock and asynchronous active-low reset; ex_* execute result handshake;
//   lsu_req_* load issue (destination enters the pending FIFO); lsu_rvalid_i/lsu_rdata_i in-order load data;
//   rf_waddr_o/rf_wdata_o/rf_we_o register-file write port; rf_busy_o per-register outstanding-load scoreboard.
// Define IBEX_RF_WB_REG_OUT_EN to present the write port from flops, one cycle after acceptance.
module ibex_rf_writeback #(
  parameter bit RV32E = 1'b0,
  parameter int DataWidth = 32,
  parameter int PendDepth = 2,
  localparam int NUM_WORDS = RV32E ? 16 : 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_req_i,
  output logic                 lsu_req_ready_o,
  input  logic [4:0]           lsu_req_waddr_i,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic [NUM_WORDS-1:0] rf_busy_o
);
  localparam int PW = PendDepth > 1 ? $clog2(PendDepth) : 1;
  localparam int CW = $clog2(PendDepth + 1);
  localparam logic [4:0] AMASK = RV32E ? 5'h0f : 5'h1f;
  logic [4:0] fifo_q [PendDepth];
  logic [PW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] cnt_q;
  logic pop, push, ex_acc, sel_valid, sel_we, stg_v;
  logic [4:0] head, sel_addr, stg_addr;
  logic [DataWidth-1:0] sel_data;
  assign head = fifo_q[rptr_q] & AMASK;
  // A response with nothing outstanding is a protocol violation and is ignored entirely.
  assign pop = lsu_rvalid_i && cnt_q != '0;
  assign lsu_req_ready_o = cnt_q < CW'(PendDepth) || pop;
  assign push = lsu_req_i && lsu_req_ready_o;
  assign ex_ready_o = !pop;
  assign ex_acc = ex_valid_i && !pop;
  assign sel_valid = pop || ex_acc;
  assign sel_addr = !sel_valid ? '0 : pop ? head : ex_waddr_i & AMASK;
  assign sel_data = !sel_valid ? '0 : pop ? lsu_rdata_i : ex_wdata_i;
  assign sel_we = sel_valid && sel_addr != '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PendDepth; i++) fifo_q[i] <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) fifo_q[wptr_q] <= lsu_req_waddr_i;
      if (push) wptr_q <= wptr_q == PW'(PendDepth - 1) ? '0 : wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q == PW'(PendDepth - 1) ? '0 : rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  // Entry i is live when its distance from the read pointer is below the count.
  always_comb begin
    rf_busy_o = '0;
    for (int r = 1; r < NUM_WORDS; r++) begin
      for (int i = 0; i < PendDepth; i++)
        if ((i + PendDepth - int'(rptr_q)) % PendDepth < int'(cnt_q) && (fifo_q[i] & AMASK) == 5'(r))
          rf_busy_o[r] = 1'b1;
      if (stg_v && stg_addr == 5'(r)) rf_busy_o[r] = 1'b1;
    end
  end
`ifdef IBEX_RF_WB_REG_OUT_EN
  logic we_q, ld_q;
  logic [4:0] waddr_q;
  logic [DataWidth-1:0] wdata_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q <= 1'b0;
      ld_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= sel_we;
      ld_q <= pop;
      waddr_q <= sel_addr;
      wdata_q <= sel_data;
    end
  end
  // A staged load keeps its register busy until the register file has actually taken it.
  assign stg_v = ld_q;
  assign stg_addr = waddr_q;
  assign rf_we_o = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;
`else
  assign stg_v = 1'b0;
  assign stg_addr = '0;
  assign rf_we_o = sel_we;
  assign rf_waddr_o = sel_addr;
  assign rf_wdata_o = sel_data;
`endif
endmodule
